// File: rtl/hms_set_ctrl_pkg.sv
// H:M:S setting controller shared types: modes, field selects and counter limits.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package hms_pkg;

  typedef enum logic {
    MODE_CLOCK = 1'b0,
    MODE_SETUP = 1'b1
  } mode_e;

  typedef enum logic [1:0] {
    POS_SEC = 2'd0,
    POS_MIN = 2'd1,
    POS_HOU = 2'd2
  } pos_e;

  localparam logic [5:0] MAX_SEC = 6'd59;
  localparam logic [5:0] MAX_MIN = 6'd59;
  localparam logic [5:0] MAX_HOU = 6'd23;

  // Field select rotation SEC -> MIN -> HOU -> SEC.
  function automatic pos_e next_pos(input pos_e p);
    case (p)
      POS_SEC: return POS_MIN;
      POS_MIN: return POS_HOU;
      default: return POS_SEC;
    endcase
  endfunction

  // Digit pair of a field within {hou_l, hou_r, min_l, min_r, sec_l, sec_r}.
  function automatic logic [5:0] field_mask(input pos_e p);
    case (p)
      POS_SEC: return 6'b00_00_11;
      POS_MIN: return 6'b00_11_00;
      POS_HOU: return 6'b11_00_00;
      default: return 6'b00_00_00;
    endcase
  endfunction

endpackage

// File: rtl/hms_set_ctrl_key_repeat.sv
// Press detector with hold-to-repeat for one active-low debounced button.
// Latency: o_pulse is combinational in the press cycle; repeats follow REP_DLY then every REP_PER cycles.
// Backpressure: none; o_pulse is a single-cycle enable with no handshake.
module key_repeat #(
  parameter int unsigned REP_DLY = 25_000_000,
  parameter int unsigned REP_PER = 5_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_sw,
  input  logic i_en,
  output logic o_pulse
);

  localparam logic [31:0] DLY    = REP_DLY;
  localparam logic [31:0] RELOAD = REP_DLY + REP_PER;

  logic        sw_q;
  logic        armed_q, armed_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] cnt_inc;
  logic        press;
  logic        held;
  logic        rep_hit;

  assign cnt_inc = cnt_q + 32'd1;
  assign press   = sw_q & ~i_sw;
  // Only a hold that started with a qualified press may repeat.
  assign held    = armed_q & ~i_sw & i_en;
  assign rep_hit = held & ((cnt_inc == DLY) | (cnt_inc == RELOAD));
  assign o_pulse = (press & i_en) | rep_hit;

  // Arm on a qualified press, count while held, reload after each periodic repeat.
  always_comb begin
    armed_d = armed_q;
    cnt_d   = cnt_q;
    if (i_sw || !i_en) begin
      armed_d = 1'b0;
      cnt_d   = '0;
    end else if (press) begin
      armed_d = 1'b1;
      cnt_d   = '0;
    end else if (armed_q) begin
      cnt_d = (cnt_inc == RELOAD) ? DLY : cnt_inc;
    end
  end

  // Button sample and repeat state registers; released button is the reset level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_q    <= 1'b1;
      armed_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sw_q    <= i_sw;
      armed_q <= armed_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/hms_set_ctrl.sv
// Turns button levels and the 1 Hz tick into H:M:S increment enables, plus mode/field/blink state.
// Latency: increment enables are registered, one cycle after the event; mode/position update at the same edge.
// Backpressure: none; enables are single-cycle pulses the counters must accept.
module hms_set_ctrl
  import hms_pkg::*;
#(
  parameter int unsigned REP_DLY    = 25_000_000,
  parameter int unsigned REP_PER    = 5_000_000,
  parameter int unsigned BLINK_HALF = 12_500_000,
  parameter int unsigned TIMEOUT    = 500_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_tick_1hz,
  input  logic       i_sw0,
  input  logic       i_sw1,
  input  logic       i_sw2,
  input  logic [5:0] i_sec,
  input  logic [5:0] i_min,
  input  logic [5:0] i_hou,
  output logic       o_mode,
  output logic [1:0] o_position,
  output logic       o_sec_inc,
  output logic       o_min_inc,
  output logic       o_hou_inc,
  output logic [5:0] o_blink_mask
);

  localparam logic [31:0] TMO   = TIMEOUT;
  localparam logic [31:0] BHALF = BLINK_HALF;

  mode_e       mode_q, mode_d;
  pos_e        pos_q, pos_d;
  logic        sw0_q, sw1_q, sw2_q;
  logic [31:0] idle_q, idle_d;
  logic [31:0] blink_cnt_q, blink_cnt_d;
  logic        blink_q, blink_d;
  logic        sec_inc_q, sec_inc_d;
  logic        min_inc_q, min_inc_d;
  logic        hou_inc_q, hou_inc_d;

  logic        press0, press1, press2, any_press;
  logic        in_setup;
  logic        timeout_hit;
  logic        rep_en;
  logic        inc_evt;
  logic        tick_clk;
  logic        sec_wrap, min_wrap;
  logic        unused_hou;

  // Hours wrap is handled by the hour counter itself; the value is not needed here.
  assign unused_hou = ^i_hou;

  assign press0    = sw0_q & ~i_sw0;
  assign press1    = sw1_q & ~i_sw1;
  assign press2    = sw2_q & ~i_sw2;
  assign any_press = press0 | press1 | press2;
  assign in_setup  = (mode_q == MODE_SETUP);

  // A press in the same cycle restarts the idle window, so it always beats the timeout.
  assign timeout_hit = in_setup & ~any_press & ((idle_q + 32'd1) >= TMO);

  // A mode press drops a simultaneous increment press and cancels any running repeat.
  assign rep_en = in_setup & ~press0;

  key_repeat #(
    .REP_DLY (REP_DLY),
    .REP_PER (REP_PER)
  ) u_key_repeat (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_sw    (i_sw2),
    .i_en    (rep_en),
    .o_pulse (inc_evt)
  );

  // Mode/field state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= MODE_CLOCK;
      pos_q  <= POS_SEC;
    end else begin
      mode_q <= mode_d;
      pos_q  <= pos_d;
    end
  end

  // Mode/field next state: mode press, then timeout, then field advance.
  always_comb begin
    mode_d = mode_q;
    pos_d  = pos_q;
    if (press0) begin
      if (in_setup) begin
        mode_d = MODE_CLOCK;
      end else begin
        mode_d = MODE_SETUP;
        pos_d  = POS_SEC;
      end
    end else if (timeout_hit) begin
      mode_d = MODE_CLOCK;
      pos_d  = POS_SEC;
    end else if (in_setup && press1) begin
      pos_d = next_pos(pos_q);
    end
  end

  // Mode/field outputs; the blink blanks the selected pair only while the increment button is up.
  always_comb begin
    o_mode       = mode_q;
    o_position   = pos_q;
    o_blink_mask = 6'b0;
    if (in_setup && i_sw2 && blink_q) begin
      o_blink_mask = field_mask(pos_q);
    end
  end

  // Idle and blink timers run only in setup and restart from zero on every entry.
  always_comb begin
    idle_d      = idle_q + 32'd1;
    blink_cnt_d = blink_cnt_q + 32'd1;
    blink_d     = blink_q;
    if (!in_setup || any_press || timeout_hit) begin
      idle_d = '0;
    end
    if (!in_setup) begin
      blink_cnt_d = '0;
      blink_d     = 1'b0;
    end else if ((blink_cnt_q + 32'd1) == BHALF) begin
      blink_cnt_d = '0;
      blink_d     = ~blink_q;
    end
  end

  // Increment enables: ticks with carry in clock mode, selected field only in setup.
  always_comb begin
    tick_clk  = i_tick_1hz & ~in_setup;
    sec_wrap  = (i_sec == MAX_SEC);
    min_wrap  = (i_min == MAX_MIN);
    sec_inc_d = tick_clk | (inc_evt & (pos_q == POS_SEC));
    min_inc_d = (tick_clk & sec_wrap) | (inc_evt & (pos_q == POS_MIN));
    hou_inc_d = (tick_clk & sec_wrap & min_wrap) | (inc_evt & (pos_q == POS_HOU));
  end

  // Switch samples, timers and registered increment enables.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw0_q       <= 1'b1;
      sw1_q       <= 1'b1;
      sw2_q       <= 1'b1;
      idle_q      <= '0;
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
      sec_inc_q   <= 1'b0;
      min_inc_q   <= 1'b0;
      hou_inc_q   <= 1'b0;
    end else begin
      sw0_q       <= i_sw0;
      sw1_q       <= i_sw1;
      sw2_q       <= i_sw2;
      idle_q      <= idle_d;
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
      sec_inc_q   <= sec_inc_d;
      min_inc_q   <= min_inc_d;
      hou_inc_q   <= hou_inc_d;
    end
  end

  assign o_sec_inc = sec_inc_q;
  assign o_min_inc = min_inc_q;
  assign o_hou_inc = hou_inc_q;

endmodule

// File: tb/tb_hms_set_ctrl.sv
// Self-checking bench for hms_set_ctrl: directed scenarios then random button/tick traffic.
// Latency: expectations for cycle N+1 are formed from the inputs applied in cycle N.
// Backpressure: n/a.
module tb_hms_set_ctrl;

  localparam int REP_DLY    = 10;
  localparam int REP_PER    = 4;
  localparam int BLINK_HALF = 3;
  localparam int TIMEOUT    = 50;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       i_tick_1hz;
  logic       i_sw0, i_sw1, i_sw2;
  logic [5:0] i_sec, i_min, i_hou;
  logic       o_mode;
  logic [1:0] o_position;
  logic       o_sec_inc, o_min_inc, o_hou_inc;
  logic [5:0] o_blink_mask;

  always #5 clk = ~clk;

  hms_set_ctrl #(
    .REP_DLY    (REP_DLY),
    .REP_PER    (REP_PER),
    .BLINK_HALF (BLINK_HALF),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_tick_1hz   (i_tick_1hz),
    .i_sw0        (i_sw0),
    .i_sw1        (i_sw1),
    .i_sw2        (i_sw2),
    .i_sec        (i_sec),
    .i_min        (i_min),
    .i_hou        (i_hou),
    .o_mode       (o_mode),
    .o_position   (o_position),
    .o_sec_inc    (o_sec_inc),
    .o_min_inc    (o_min_inc),
    .o_hou_inc    (o_hou_inc),
    .o_blink_mask (o_blink_mask)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int npulse = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model, kept as event times rather than counters.
  int cyc = 0;
  int m_mode, m_pos;
  int m_prev0, m_prev1, m_prev2;
  int m_hold, m_hold_start;
  int m_last, m_entry;
  int e_sec, e_min, e_hou;

  task automatic model_reset();
    m_mode = 0; m_pos = 0;
    m_prev0 = 1; m_prev1 = 1; m_prev2 = 1;
    m_hold = 0; m_hold_start = 0;
    m_last = cyc; m_entry = cyc;
    e_sec = 0; e_min = 0; e_hou = 0;
  endtask

  function automatic int exp_mask();
    int phase;
    phase = ((cyc - m_entry - 1) / BLINK_HALF) % 2;
    if (m_mode == 1 && i_sw2 == 1'b1 && phase == 1) return 3 << (2 * m_pos);
    return 0;
  endfunction

  task automatic model_step();
    int p0, p1, p2, setup, evt, age, tmo;
    p0 = (m_prev0 == 1 && i_sw0 == 1'b0) ? 1 : 0;
    p1 = (m_prev1 == 1 && i_sw1 == 1'b0) ? 1 : 0;
    p2 = (m_prev2 == 1 && i_sw2 == 1'b0) ? 1 : 0;
    setup = m_mode;
    evt = 0;
    e_sec = 0; e_min = 0; e_hou = 0;
    if (setup == 0 && i_tick_1hz == 1'b1) begin
      e_sec = 1;
      e_min = (i_sec == 6'd59) ? 1 : 0;
      e_hou = (i_sec == 6'd59 && i_min == 6'd59) ? 1 : 0;
    end
    if (setup == 1 && p0 == 0 && p2 == 1) begin
      evt = 1; m_hold = 1; m_hold_start = cyc;
    end else if (setup == 1 && p0 == 0 && m_hold == 1 && i_sw2 == 1'b0) begin
      age = cyc - m_hold_start;
      if (age >= REP_DLY && (age - REP_DLY) % REP_PER == 0) evt = 1;
    end else begin
      m_hold = 0;
    end
    if (evt == 1) begin
      if (m_pos == 0) e_sec = 1;
      else if (m_pos == 1) e_min = 1;
      else e_hou = 1;
    end
    if (p0 + p1 + p2 > 0) m_last = cyc;
    tmo = (setup == 1 && p0 + p1 + p2 == 0 && cyc - m_last >= TIMEOUT) ? 1 : 0;
    if (p0 == 1) begin
      m_mode = 1 - m_mode;
      if (m_mode == 1) begin m_pos = 0; m_entry = cyc; end
    end else if (tmo == 1) begin
      m_mode = 0; m_pos = 0;
    end else if (setup == 1 && p1 == 1) begin
      m_pos = (m_pos + 1) % 3;
    end
    m_prev0 = int'(i_sw0); m_prev1 = int'(i_sw1); m_prev2 = int'(i_sw2);
    cyc++;
  endtask

  // One clock cycle: entered and left 1 time unit after a rising edge.
  task automatic step(input int s0, input int s1, input int s2, input int tk,
                      input int sc, input int mn, input int hr);
    i_sw0 = (s0 != 0); i_sw1 = (s1 != 0); i_sw2 = (s2 != 0);
    i_tick_1hz = (tk != 0);
    i_sec = 6'(sc); i_min = 6'(mn); i_hou = 6'(hr);
    #2;
    chk("blink_mask", int'(o_blink_mask), exp_mask());
    model_step();
    @(posedge clk); #1;
    chk("mode", int'(o_mode), m_mode);
    chk("position", int'(o_position), m_pos);
    chk("sec_inc", int'(o_sec_inc), e_sec);
    chk("min_inc", int'(o_min_inc), e_min);
    chk("hou_inc", int'(o_hou_inc), e_hou);
    npulse += int'(o_sec_inc) + int'(o_min_inc) + int'(o_hou_inc);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 1, 1, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_mode", int'(o_mode), 0);
    chk("rst_position", int'(o_position), 0);
    chk("rst_incs", int'(o_sec_inc) + int'(o_min_inc) + int'(o_hou_inc), 0);
    chk("rst_mask", int'(o_blink_mask), 0);
    i_sw0 = 1'b1; i_sw1 = 1'b1; i_sw2 = 1'b1; i_tick_1hz = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  int rep_at[6] = '{1, 11, 15, 19, 23, 27};
  int wrap_exp[3] = '{1, 2, 0};
  int hit;
  int h0, h1, h2;
  int s0, s1, s2;

  initial begin
    rst_n = 1'b0;
    i_tick_1hz = 1'b0; i_sw0 = 1'b1; i_sw1 = 1'b1; i_sw2 = 1'b1;
    i_sec = '0; i_min = '0; i_hou = '0;
    #3;
    do_reset();

    // carry chain on a 1 Hz tick at 05:59:59
    step(1, 1, 1, 1, 59, 59, 5);
    chk("carry_sec", int'(o_sec_inc), 1);
    chk("carry_min", int'(o_min_inc), 1);
    chk("carry_hou", int'(o_hou_inc), 1);
    step(1, 1, 1, 0, 0, 0, 6);
    chk("carry_width", int'(o_sec_inc) + int'(o_min_inc) + int'(o_hou_inc), 0);
    step(1, 1, 1, 1, 12, 59, 6);
    chk("nocarry_min", int'(o_min_inc), 0);

    // setup increment on the minutes field
    step(0, 1, 1, 0, 0, 0, 0); step(1, 1, 1, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0, 0); step(1, 1, 1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0);
    chk("setup_mode", int'(o_mode), 1);
    chk("setup_pos", int'(o_position), 1);
    chk("setup_min_inc", int'(o_min_inc), 1);
    chk("setup_other_inc", int'(o_sec_inc) + int'(o_hou_inc), 0);
    step(1, 1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 1, 1, 59, 59, 23);
      chk("setup_tick_frozen", int'(o_sec_inc) + int'(o_min_inc) + int'(o_hou_inc), 0);
    end

    // position wrap after a fresh entry
    step(0, 1, 1, 0, 0, 0, 0); step(1, 1, 1, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0, 0); step(1, 1, 1, 0, 0, 0, 0);
    chk("reenter_pos", int'(o_position), 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 1, 0, 0, 0, 0);
      chk("wrap_pos", int'(o_position), wrap_exp[i]);
      step(1, 1, 1, 0, 0, 0, 0);
    end

    // auto-repeat on the seconds field, held for 30 cycles
    npulse = 0;
    for (int k = 0; k < 30; k++) begin
      step(1, 1, 0, 0, 0, 0, 0);
      hit = 0;
      foreach (rep_at[j]) if (rep_at[j] == k + 1) hit = 1;
      chk("repeat_pulse", int'(o_sec_inc), hit);
    end
    step(1, 1, 1, 0, 0, 0, 0);
    chk("repeat_count", npulse, 6);

    // setup timeout
    step(0, 1, 1, 0, 0, 0, 0); step(1, 1, 1, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0, 0);
    idle(49);
    chk("tmo_still_setup", int'(o_mode), 1);
    idle(1);
    chk("tmo_mode", int'(o_mode), 0);
    chk("tmo_pos", int'(o_position), 0);
    chk("tmo_mask", int'(o_blink_mask), 0);

    // mode press wins over a same-cycle increment or position press
    step(0, 1, 1, 0, 0, 0, 0); step(1, 1, 1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0);
    chk("simul_mode", int'(o_mode), 0);
    chk("simul_inc", int'(o_sec_inc) + int'(o_min_inc) + int'(o_hou_inc), 0);
    step(1, 1, 1, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0, 0); step(1, 1, 1, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0, 0); step(1, 1, 1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0);
    chk("simul_pos_mode", int'(o_mode), 0);
    chk("simul_pos_kept", int'(o_position), 1);
    step(1, 1, 1, 0, 0, 0, 0);

    // asynchronous reset in the middle of a repeat pulse
    step(0, 1, 1, 0, 0, 0, 0); step(1, 1, 1, 0, 0, 0, 0);
    for (int k = 0; k < 11; k++) step(1, 1, 0, 0, 0, 0, 0);
    chk("pre_reset_pulse", int'(o_sec_inc), 1);
    do_reset();
    idle(3);

    // random traffic
    h0 = 0; h1 = 0; h2 = 0;
    for (int n = 0; n < 3000; n++) begin
      if (h0 > 0) begin s0 = 0; h0--; end
      else begin s0 = 1; if ($urandom_range(59, 0) == 0) h0 = int'($urandom_range(3, 1)); end
      if (h1 > 0) begin s1 = 0; h1--; end
      else begin s1 = 1; if ($urandom_range(7, 0) == 0) h1 = int'($urandom_range(3, 1)); end
      if (h2 > 0) begin s2 = 0; h2--; end
      else begin s2 = 1; if ($urandom_range(5, 0) == 0) h2 = int'($urandom_range(25, 1)); end
      step(s0, s1, s2, ($urandom_range(7, 0) == 0) ? 1 : 0,
           ($urandom_range(3, 0) == 0) ? 59 : int'($urandom_range(59, 0)),
           ($urandom_range(1, 0) == 0) ? 59 : int'($urandom_range(59, 0)),
           int'($urandom_range(23, 0)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
